// File: rtl/regfile_access_arbiter.sv
// Shares the regfile auxiliary port between soc_control (DBG) and fault injection (FI), halting the core first.
// Optional halt watchdog enabled by defining ARB_HALT_TIMEOUT_EN.

`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module regfile_access_arbiter #(
    parameter int RELEASE_DELAY = 4
`ifdef ARB_HALT_TIMEOUT_EN
    ,
    parameter int HALT_TIMEOUT  = 64
`endif
) (
    input  logic                        CLK,
    input  logic                        RSTn,
    output logic                        cpu_stop,
    input  logic                        cpu_halted,
    input  logic                        dbg_req,
    input  logic                        dbg_we,
    input  logic [`REG_ADDR_WIDTH-1:0]  dbg_addr,
    input  logic [`DATA_WIDTH-1:0]      dbg_wdata,
    output logic                        dbg_ack,
    output logic                        dbg_err,
    output logic [`DATA_WIDTH-1:0]      dbg_rdata,
    input  logic                        fi_req,
    input  logic                        fi_we,
    input  logic [`REG_ADDR_WIDTH-1:0]  fi_addr,
    input  logic [`DATA_WIDTH-1:0]      fi_wdata,
    output logic                        fi_ack,
    output logic                        fi_err,
    output logic [`DATA_WIDTH-1:0]      fi_rdata,
    output logic [`REG_ADDR_WIDTH-1:0]  rf_addr,
    output logic                        rf_write_enable,
    output logic [`DATA_WIDTH-1:0]      rf_write_data,
    input  logic [`DATA_WIDTH-1:0]      rf_read_data
);

    localparam int AW = `REG_ADDR_WIDTH;
    localparam int DW = `DATA_WIDTH;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_HALT_WAIT,
        ST_ISSUE,
        ST_CAPTURE,
        ST_HOLD
    } state_e;

    typedef enum logic {
        GNT_DBG = 1'b0,
        GNT_FI  = 1'b1
    } grant_e;

    state_e        state_q, state_d;
    grant_e        grant_q, grant_d;
    grant_e        last_grant_q, last_grant_d;
    logic [7:0]    hold_cnt_q, hold_cnt_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
    logic [DW-1:0] fi_rdata_q, fi_rdata_d;

`ifdef ARB_HALT_TIMEOUT_EN
    localparam int TW = ($clog2(HALT_TIMEOUT) > 0) ? $clog2(HALT_TIMEOUT) : 1;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
`endif

    logic          any_req;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_x0_write;
    logic          other_req;

    // Round-robin pick: a tie goes to whoever was not served last.
    function automatic grant_e pick_grant(input logic d_req, input logic f_req, input grant_e last);
        if (d_req && f_req) begin
            return (last == GNT_DBG) ? GNT_FI : GNT_DBG;
        end
        return d_req ? GNT_DBG : GNT_FI;
    endfunction

    assign any_req      = dbg_req | fi_req;
    assign sel_we       = (grant_q == GNT_FI) ? fi_we    : dbg_we;
    assign sel_addr     = (grant_q == GNT_FI) ? fi_addr  : dbg_addr;
    assign sel_wdata    = (grant_q == GNT_FI) ? fi_wdata : dbg_wdata;
    assign sel_x0_write = sel_we && (sel_addr == '0);
    assign other_req    = (grant_q == GNT_FI) ? dbg_req : fi_req;

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        last_grant_d    = last_grant_q;
        hold_cnt_d      = hold_cnt_q;
        dbg_rdata_d     = dbg_rdata_q;
        fi_rdata_d      = fi_rdata_q;
        cpu_stop        = (state_q != ST_RUN);
        rf_addr         = '0;
        rf_write_enable = 1'b0;
        rf_write_data   = '0;
        dbg_ack         = 1'b0;
        dbg_err         = 1'b0;
        fi_ack          = 1'b0;
        fi_err          = 1'b0;
`ifdef ARB_HALT_TIMEOUT_EN
        to_cnt_d        = to_cnt_q;
`endif

        case (state_q)
            ST_RUN: begin
`ifdef ARB_HALT_TIMEOUT_EN
                to_cnt_d = '0;
`endif
                if (any_req) begin
                    state_d = ST_HALT_WAIT;
                end
            end

            ST_HALT_WAIT: begin
                if (cpu_halted) begin
                    if (any_req) begin
                        state_d = ST_ISSUE;
                        grant_d = pick_grant(dbg_req, fi_req, last_grant_q);
                    end else begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = 8'(RELEASE_DELAY - 1);
                    end
                end
`ifdef ARB_HALT_TIMEOUT_EN
                // Core never stopped: refuse everything pending and let it run again.
                else if (to_cnt_q == TW'(HALT_TIMEOUT - 1)) begin
                    dbg_ack = dbg_req;
                    dbg_err = dbg_req;
                    fi_ack  = fi_req;
                    fi_err  = fi_req;
                    state_d = ST_RUN;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end

            ST_ISSUE: begin
                rf_addr         = sel_addr;
                rf_write_data   = sel_wdata;
                rf_write_enable = sel_we && !sel_x0_write;
                state_d         = ST_CAPTURE;
            end

            ST_CAPTURE: begin
                if (grant_q == GNT_FI) begin
                    fi_ack = 1'b1;
                    fi_err = sel_x0_write;
                    if (!sel_we) begin
                        fi_rdata_d = rf_read_data;
                    end
                end else begin
                    dbg_ack = 1'b1;
                    dbg_err = sel_x0_write;
                    if (!sel_we) begin
                        dbg_rdata_d = rf_read_data;
                    end
                end
                last_grant_d = grant_q;
                if (other_req) begin
                    state_d = ST_ISSUE;
                    grant_d = (grant_q == GNT_FI) ? GNT_DBG : GNT_FI;
                end else begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = 8'(RELEASE_DELAY - 1);
                end
            end

            ST_HOLD: begin
                if (any_req) begin
                    state_d = ST_ISSUE;
                    grant_d = pick_grant(dbg_req, fi_req, last_grant_q);
                end else if (hold_cnt_q == 8'd0) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q - 8'd1;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Read data is visible in the ack cycle, then held until that requester's next read.
    assign dbg_rdata = dbg_rdata_d;
    assign fi_rdata  = fi_rdata_d;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q      <= ST_RUN;
            grant_q      <= GNT_DBG;
            last_grant_q <= GNT_FI;
            hold_cnt_q   <= 8'd0;
            dbg_rdata_q  <= '0;
            fi_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            hold_cnt_q   <= hold_cnt_d;
            dbg_rdata_q  <= dbg_rdata_d;
            fi_rdata_q   <= fi_rdata_d;
        end
    end

`ifdef ARB_HALT_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Scoreboard bench for regfile_access_arbiter with a behavioural regfile and a core that halts a few cycles after cpu_stop.
`timescale 1ns/1ps

module tb_regfile_access_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int RD = 4;

    logic          CLK = 1'b0;
    logic          RSTn;
    logic          cpu_stop;
    logic          cpu_halted = 1'b0;
    logic          dbgReq, dbgWe, fiReq, fiWe;
    logic [AW-1:0] dbgAddr, fiAddr;
    logic [DW-1:0] dbgWdata, fiWdata;
    logic          dbg_ack, dbg_err, fi_ack, fi_err;
    logic [DW-1:0] dbg_rdata, fi_rdata;
    logic [AW-1:0] rf_addr;
    logic          rf_write_enable;
    logic [DW-1:0] rf_write_data;
    logic [DW-1:0] rf_read_data = '0;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    regfile_access_arbiter #(
        .RELEASE_DELAY(RD)
`ifdef ARB_HALT_TIMEOUT_EN
        , .HALT_TIMEOUT(8)
`endif
    ) dut (
        .CLK(CLK), .RSTn(RSTn),
        .cpu_stop(cpu_stop), .cpu_halted(cpu_halted),
        .dbg_req(dbgReq), .dbg_we(dbgWe), .dbg_addr(dbgAddr), .dbg_wdata(dbgWdata),
        .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
        .fi_req(fiReq), .fi_we(fiWe), .fi_addr(fiAddr), .fi_wdata(fiWdata),
        .fi_ack(fi_ack), .fi_err(fi_err), .fi_rdata(fi_rdata),
        .rf_addr(rf_addr), .rf_write_enable(rf_write_enable),
        .rf_write_data(rf_write_data), .rf_read_data(rf_read_data)
    );

    // Regfile environment: x0 hardwired to zero, read data one cycle after the address.
    logic [DW-1:0] rfMem [32];
    always @(posedge CLK) begin
        if (rf_write_enable && rf_addr != 0) rfMem[rf_addr] <= rf_write_data;
        rf_read_data <= (rf_addr == 0) ? '0 : rfMem[rf_addr];
    end

    // Core model: halts haltDelay cycles after cpu_stop rises, resumes once it drops.
    int haltDelay  = 3;
    bit haltEnable = 1'b1;
    int haltCnt    = 0;
    always @(posedge CLK) begin
        if (!cpu_stop) begin
            cpu_halted <= 1'b0;
            haltCnt    <= 0;
        end else if (haltEnable && haltCnt >= haltDelay - 1) begin
            cpu_halted <= 1'b1;
        end else begin
            haltCnt <= haltCnt + 1;
        end
    end

    typedef struct packed {
        logic          fi;
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          sbQ[$];
    logic [DW-1:0] regModel [32];
    logic [DW-1:0] lastRdata [2];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic scoreboardPop(input logic isFi, input logic err, input logic [DW-1:0] rdata);
        exp_t e;
        checkOutput(isFi ? "fi ack pending" : "dbg ack pending", 64'(sbQ.size() != 0), 64'(1));
        if (sbQ.size() != 0) begin
            e = sbQ.pop_front();
            checkOutput("ack source", 64'(isFi), 64'(e.fi));
            checkOutput(isFi ? "fi_err" : "dbg_err", 64'(err), 64'(e.err));
            checkOutput(isFi ? "fi_rdata" : "dbg_rdata", 64'(rdata), 64'(e.rdata));
        end
    endtask

    always @(negedge CLK) begin
        if (RSTn) begin
            if (dbg_ack) scoreboardPop(1'b0, dbg_err, dbg_rdata);
            if (fi_ack)  scoreboardPop(1'b1, fi_err, fi_rdata);
        end
    end

    // kind: 0 normal access, 1 dropped by reset (no ack), 2 refused by halt timeout.
    task automatic applyStimulus(input bit isFi, input bit we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input int kind);
        exp_t e;
        if (isFi) begin
            fiReq = 1'b1; fiWe = we; fiAddr = addr; fiWdata = wdata;
        end else begin
            dbgReq = 1'b1; dbgWe = we; dbgAddr = addr; dbgWdata = wdata;
        end
        if (kind != 1) begin
            e.fi    = isFi;
            e.err   = (kind == 2) || (we && addr == 0);
            e.rdata = (!we && kind == 0) ? ((addr == 0) ? '0 : regModel[addr]) : lastRdata[isFi];
            lastRdata[isFi] = e.rdata;
            if (kind == 0 && we && addr != 0) regModel[addr] = wdata;
            sbQ.push_back(e);
        end
    endtask

    int dbgAckCycle, fiAckCycle, stopRiseCycle, haltRiseCycle;
    bit sawStopDrop, sawRfWe;

    // Runs until every raised request is acked; drops each req the cycle after its ack.
    task automatic waitAcks(input int budget);
        int cyc = 0;
        bit dAck, fAck;
        dbgAckCycle = -1; fiAckCycle = -1; stopRiseCycle = -1; haltRiseCycle = -1;
        sawStopDrop = 1'b0; sawRfWe = 1'b0;
        while ((dbgReq || fiReq) && cyc < budget) begin
            @(negedge CLK);
            dAck = dbg_ack;
            fAck = fi_ack;
            if (cpu_stop && stopRiseCycle < 0) stopRiseCycle = cyc;
            if (!cpu_stop && stopRiseCycle >= 0) sawStopDrop = 1'b1;
            if (cpu_halted && haltRiseCycle < 0) haltRiseCycle = cyc;
            if (rf_write_enable) sawRfWe = 1'b1;
            if (dAck && dbgAckCycle < 0) dbgAckCycle = cyc;
            if (fAck && fiAckCycle < 0) fiAckCycle = cyc;
            @(posedge CLK);
            #1;
            if (dAck) dbgReq = 1'b0;
            if (fAck) fiReq = 1'b0;
            cyc++;
        end
        checkOutput("requests retired", 64'(dbgReq || fiReq), 64'(0));
        dbgReq = 1'b0;
        fiReq  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global timeout");
        $fatal(1, "[TB] simulation did not terminate");
    end

    initial begin
        bit found;
        for (int i = 0; i < 32; i++) regModel[i] = '0;
        lastRdata[0] = '0;
        lastRdata[1] = '0;
        dbgReq = 0; dbgWe = 0; dbgAddr = '0; dbgWdata = '0;
        fiReq = 0; fiWe = 0; fiAddr = '0; fiWdata = '0;
        RSTn = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("reset cpu_stop", 64'(cpu_stop), 64'(0));
        checkOutput("reset acks", 64'({dbg_ack, fi_ack, dbg_err, fi_err}), 64'(0));
        checkOutput("reset rf outputs", 64'({rf_write_enable, rf_addr, rf_write_data}), 64'(0));
        checkOutput("reset rdata", 64'({dbg_rdata, fi_rdata}), 64'(0));
        RSTn = 1'b1;

        $display("[TB] simultaneous writes after reset");
        @(posedge CLK); #1;
        applyStimulus(1'b0, 1'b1, 5'd3, 32'h11, 0);
        applyStimulus(1'b1, 1'b1, 5'd4, 32'h22, 0);
        waitAcks(40);
        checkOutput("t2 dbg ack cycle", 64'(dbgAckCycle), 64'(haltRiseCycle + 2));
        checkOutput("t2 fi ack cycle", 64'(fiAckCycle), 64'(dbgAckCycle + 2));
        checkOutput("t2 cpu_stop held", 64'(sawStopDrop), 64'(0));
        checkOutput("t2 x3", 64'(rfMem[3]), 64'(32'h11));
        checkOutput("t2 x4", 64'(rfMem[4]), 64'(32'h22));
        idle(10);

        applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 0);
        waitAcks(40);
        idle(10);

        $display("[TB] read from running core");
        applyStimulus(1'b0, 1'b0, 5'd5, '0, 0);
        waitAcks(40);
        checkOutput("t1 stop rise", 64'(stopRiseCycle), 64'(1));
        checkOutput("t1 halt rise", 64'(haltRiseCycle), 64'(1 + haltDelay));
        checkOutput("t1 ack cycle", 64'(dbgAckCycle), 64'(haltRiseCycle + 2));
        for (int i = 1; i <= RD + 1; i++) begin
            @(negedge CLK);
            checkOutput("t1 release timing", 64'(cpu_stop), 64'(i <= RD));
        end
        idle(6);

        $display("[TB] write to x0");
        applyStimulus(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 0);
        waitAcks(40);
        checkOutput("t3 rf_write_enable", 64'(sawRfWe), 64'(0));
        applyStimulus(1'b1, 1'b0, 5'd0, '0, 0);
        waitAcks(40);
        idle(10);

        $display("[TB] request during hold");
        applyStimulus(1'b0, 1'b0, 5'd3, '0, 0);
        waitAcks(40);
        applyStimulus(1'b1, 1'b0, 5'd5, '0, 0);
        waitAcks(40);
        checkOutput("t4 fi latency", 64'(fiAckCycle), 64'(2));
        checkOutput("t4 cpu_stop held", 64'(sawStopDrop), 64'(0));
        idle(10);

        $display("[TB] reset during issue");
        applyStimulus(1'b0, 1'b1, 5'd7, 32'h77, 1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge CLK);
            if (rf_write_enable) found = 1'b1;
        end
        checkOutput("t5 issue reached", 64'(found), 64'(1));
        #1 RSTn = 1'b0;
        #1;
        checkOutput("t5 cpu_stop", 64'(cpu_stop), 64'(0));
        checkOutput("t5 rf_write_enable", 64'(rf_write_enable), 64'(0));
        checkOutput("t5 acks", 64'({dbg_ack, fi_ack}), 64'(0));
        checkOutput("t5 dbg_rdata", 64'(dbg_rdata), 64'(0));
        dbgReq = 1'b0;
        lastRdata[0] = '0;
        lastRdata[1] = '0;
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        repeat (8) @(negedge CLK);
        checkOutput("t5 idle after reset", 64'(cpu_stop), 64'(0));
        checkOutput("t5 x7 untouched", 64'(rfMem[7]), 64'(0));
        @(posedge CLK); #1;
        applyStimulus(1'b1, 1'b0, 5'd4, '0, 0);
        applyStimulus(1'b0, 1'b0, 5'd3, '0, 0);
        sbQ.reverse();
        waitAcks(40);
        checkOutput("t5 dbg wins tie", 64'(dbgAckCycle < fiAckCycle), 64'(1));
        idle(10);

`ifdef ARB_HALT_TIMEOUT_EN
        $display("[TB] halt timeout");
        haltEnable = 1'b0;
        applyStimulus(1'b0, 1'b1, 5'd9, 32'h99, 2);
        waitAcks(40);
        checkOutput("t6 timeout cycle", 64'(dbgAckCycle), 64'(8));
        @(negedge CLK);
        checkOutput("t6 cpu_stop dropped", 64'(cpu_stop), 64'(0));
        checkOutput("t6 x9 untouched", 64'(rfMem[9]), 64'(0));
        haltEnable = 1'b1;
        idle(10);
`endif

        checkOutput("scoreboard drained", 64'(sbQ.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
